cache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller between the multicycle MIPS data port and a slow single-port main data memory.
- Serves read hits with zero stall.
- Sequences read-miss line fills and all write-through transactions on the memory side.
- Drives the `stall` signal the CPU samples in its Memory state.
- Keeps hit/miss statistics for display on the board.

---
 rtl/cache_controller.sv | 112 +++++++++++
 tb/tb_cache_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU data port
// and a slow single-port main memory; one word per line, hit/miss statistics for the board.
module cache_controller #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              r_en,
   input  logic              w_en,
   output logic [DATA_W-1:0] saida_cache,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_r_en,
   output logic              mem_w_en,
   input  logic [DATA_W-1:0] mem_q,
   input  logic              mem_ready,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;
   state_t state;

   logic [LINES-1:0]   valid_bits;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [DATA_W-1:0]  line_mem [LINES];

   logic [INDEX_W-1:0] index;
   logic [INDEX_W-1:0] fill_index;
   logic [TAG_W-1:0]   tag;
   logic [TAG_W-1:0]   fill_tag;
   logic               hit;

   assign index      = address[INDEX_W-1:0];
   assign tag        = address[ADDR_W-1:INDEX_W];
   // The pending transaction's line is taken from the latched memory address.
   assign fill_index = mem_address[INDEX_W-1:0];
   assign fill_tag   = mem_address[ADDR_W-1:INDEX_W];
   assign hit        = valid_bits[index] && (tag_mem[index] == tag);

   assign mem_r_en = (state == RD_MISS);
   assign mem_w_en = (state == WR_THRU);

   always_comb begin
      stall       = 1'b0;
      saida_cache = '0;
      case (state)
         IDLE: begin
            stall = w_en || (r_en && !hit);
            if (r_en && !w_en && hit) saida_cache = line_mem[index];
         end
         RD_MISS, WR_THRU: stall = 1'b1;
         DONE:             saida_cache = line_mem[fill_index];
         default:          stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         valid_bits  <= '0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
         mem_address <= '0;
         mem_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (w_en) begin
                  mem_address <= address;
                  mem_data    <= data;
                  state       <= WR_THRU;
               end else if (r_en) begin
                  if (hit) begin
                     hit_cnt <= hit_cnt + 16'd1;
                  end else begin
                     mem_address <= address;
                     miss_cnt    <= miss_cnt + 16'd1;
                     state       <= RD_MISS;
                  end
               end
            end
            RD_MISS: begin
               if (mem_ready) begin
                  valid_bits[fill_index] <= 1'b1;
                  state                  <= DONE;
               end
            end
            WR_THRU: if (mem_ready) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data storage has no reset; valid bits alone decide whether a line is usable.
   always_ff @(posedge clk) begin
      if (state == IDLE && w_en && hit) begin
         line_mem[index] <= data;
      end else if (state == RD_MISS && mem_ready) begin
         line_mem[fill_index] <= mem_q;
         tag_mem[fill_index]  <= fill_tag;
      end
   end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, randomized traffic against a
// line-address reference model, reset-in-flight and hit counter wrap sequences.
module tb_cache_controller;
   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] address;
   logic [31:0] data;
   logic        r_en;
   logic        w_en;
   logic [31:0] saida_cache;
   logic        stall;
   logic [11:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_q;
   logic        mem_ready;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   logic [31:0] main_mem [4096];
   int          line_addr [16];
   int          exp_hit;
   int          exp_miss;
   int          n_checks = 0;
   int          n_fail   = 0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [11:0] a;
      logic [31:0] d;
      int          delay;
      logic        chk_data;
      logic [31:0] exp_data;
      int          exp_stalls;
      int          exp_hit;
      int          exp_miss;
   } vec_t;
   vec_t vec [9];

   always #5 clk = ~clk;
   assign mem_q = main_mem[mem_address];

   cache_controller #(.ADDR_W(12), .DATA_W(32), .INDEX_W(4)) dut (
      .clk(clk), .reset(reset), .address(address), .data(data), .r_en(r_en), .w_en(w_en),
      .saida_cache(saida_cache), .stall(stall), .mem_address(mem_address), .mem_data(mem_data),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_q(mem_q), .mem_ready(mem_ready),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) line_addr[i] = -1;
      exp_hit  = 0;
      exp_miss = 0;
   endtask

   // Presents one CPU request, plays the slow memory, and reports what the CPU observed.
   task automatic access(input logic wr, input logic rd, input logic [11:0] a, input logic [31:0] d,
                         input int delay, output logic [31:0] rdata, output int stalls,
                         output logic saw_r, output logic saw_w);
      int   waits = 0;
      logic done  = 1'b0;
      stalls = 0;
      saw_r  = 1'b0;
      saw_w  = 1'b0;
      rdata  = '0;
      @(posedge clk); #1;
      address = a; data = d; w_en = wr; r_en = rd;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (!stall) begin
            rdata = saida_cache;
            done  = 1'b1;
         end else begin
            stalls++;
            if (mem_r_en || mem_w_en) begin
               waits++;
               saw_r = saw_r | mem_r_en;
               saw_w = saw_w | mem_w_en;
               check("mem_en_exclusive", 32'(mem_r_en & mem_w_en), 32'd0);
               if (waits == 1) begin
                  check("mem_address", 32'(mem_address), 32'(a));
                  if (wr) check("mem_data", mem_data, d);
               end
               if (waits == delay) mem_ready = 1'b1;
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL access_timeout: stall still %b after 64 cycles, expected 0", stall);
      end
      @(posedge clk); #1;
      r_en = 1'b0;
      w_en = 1'b0;
   endtask

   // Reference: a line holds exactly one word address, and with write-through its data is main_mem.
   task automatic run_op(input logic wr, input logic rd, input logic [11:0] a, input logic [31:0] d,
                         input int delay, output logic [31:0] rdata, output int stalls);
      logic is_load, is_hit, saw_r, saw_w;
      int   idx;
      idx     = int'(a[3:0]);
      is_load = rd && !wr;
      is_hit  = (line_addr[idx] == int'(a));
      access(wr, rd, a, d, delay, rdata, stalls, saw_r, saw_w);
      check("stall_cycles", 32'(stalls), 32'((is_load && is_hit) ? 0 : delay + 1));
      check("mem_r_en_seen", 32'(saw_r), 32'(is_load && !is_hit));
      check("mem_w_en_seen", 32'(saw_w), 32'(wr));
      if (is_load) begin
         check("load_data", rdata, main_mem[a]);
         if (is_hit) exp_hit = (exp_hit + 1) % 65536;
         else begin
            exp_miss       = (exp_miss + 1) % 65536;
            line_addr[idx] = int'(a);
         end
      end
      if (wr) main_mem[a] = d;
      check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
      check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
   endtask

   initial begin
      logic [31:0] rdata;
      int          stalls;
      int          r;
      logic        wr, rd;
      logic [11:0] a;

      for (int i = 0; i < 4096; i++) main_mem[i] = 32'hC0DE0000 | i;
      main_mem[12'h012] = 32'hDEADBEEF;
      main_mem[12'h112] = 32'h11111111;
      vec[0] = '{1'b0, 1'b1, 12'h012, 32'h0,        2, 1'b1, 32'hDEADBEEF, 3, 0, 1};
      vec[1] = '{1'b0, 1'b1, 12'h012, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 1, 1};
      vec[2] = '{1'b0, 1'b1, 12'h112, 32'h0,        1, 1'b1, 32'h11111111, 2, 1, 2};
      vec[3] = '{1'b0, 1'b1, 12'h012, 32'h0,        3, 1'b1, 32'hDEADBEEF, 4, 1, 3};
      vec[4] = '{1'b1, 1'b0, 12'h012, 32'h0000ABCD, 2, 1'b1, 32'h0000ABCD, 3, 1, 3};
      vec[5] = '{1'b0, 1'b1, 12'h012, 32'h0,        1, 1'b1, 32'h0000ABCD, 0, 2, 3};
      vec[6] = '{1'b1, 1'b0, 12'h034, 32'h12345678, 1, 1'b0, 32'h0,        2, 2, 3};
      vec[7] = '{1'b0, 1'b1, 12'h034, 32'h0,        1, 1'b1, 32'h12345678, 2, 2, 4};
      vec[8] = '{1'b1, 1'b1, 12'h005, 32'hCAFEF00D, 2, 1'b0, 32'h0,        3, 2, 4};

      reset = 1'b1; address = '0; data = '0; r_en = 1'b0; w_en = 1'b0; mem_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", 32'(stall), 32'd0);
      check("reset_mem_r_en", 32'(mem_r_en), 32'd0);
      check("reset_mem_w_en", 32'(mem_w_en), 32'd0);
      check("reset_hit_cnt", 32'(hit_cnt), 32'd0);
      check("reset_miss_cnt", 32'(miss_cnt), 32'd0);
      check("reset_mem_address", 32'(mem_address), 32'd0);
      check("reset_mem_data", mem_data, 32'd0);
      check("reset_saida", saida_cache, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vec[i].wr, vec[i].rd, vec[i].a, vec[i].d, vec[i].delay, rdata, stalls);
         check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(vec[i].exp_stalls));
         if (vec[i].chk_data) check($sformatf("vec%0d_data", i), rdata, vec[i].exp_data);
         check($sformatf("vec%0d_hit_cnt", i), 32'(hit_cnt), 32'(vec[i].exp_hit));
         check($sformatf("vec%0d_miss_cnt", i), 32'(miss_cnt), 32'(vec[i].exp_miss));
      end

      for (int n = 0; n < 150; n++) begin
         r  = int'($urandom_range(0, 99));
         wr = (r >= 60);
         rd = (r < 60) || (r >= 85);
         a  = {($urandom_range(0, 1) == 1) ? 4'hF : 4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
         run_op(wr, rd, a, $urandom, int'($urandom_range(1, 4)), rdata, stalls);
      end

      // Reset while a fill is outstanding: the memory side must drop at once.
      @(posedge clk); #1;
      address = 12'h0A7; r_en = 1'b1;
      for (int i = 0; i < 8 && !mem_r_en; i++) @(negedge clk);
      check("midmiss_mem_r_en", 32'(mem_r_en), 32'd1);
      #2;
      r_en  = 1'b0;
      reset = 1'b1;
      #1;
      check("async_mem_r_en", 32'(mem_r_en), 32'd0);
      check("async_stall", 32'(stall), 32'd0);
      check("async_hit_cnt", 32'(hit_cnt), 32'd0);
      check("async_miss_cnt", 32'(miss_cnt), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      run_op(1'b0, 1'b1, 12'h0A7, 32'h0, 2, rdata, stalls);
      run_op(1'b0, 1'b1, 12'h012, 32'h0, 1, rdata, stalls);

      // Continuous hits on one line: 65535 hits then the wrap to zero.
      @(posedge clk); #1;
      address = 12'h0A7; r_en = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      check("wrap_hit_cnt_ffff", 32'(hit_cnt), 32'h0000FFFF);
      check("wrap_stall", 32'(stall), 32'd0);
      check("wrap_saida", saida_cache, main_mem[12'h0A7]);
      @(posedge clk); #1;
      r_en = 1'b0;
      check("wrap_hit_cnt_zero", 32'(hit_cnt), 32'd0);
      check("wrap_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
      exp_hit = 0;
      run_op(1'b0, 1'b1, 12'h0A7, 32'h0, 1, rdata, stalls);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
